// File: rtl/nexys4ddr_reset_request.sv
// Board-level reset request generator: merges button, software, watchdog and MMCM lock-loss
// causes into a held areset, sequenced against the downstream reset acknowledge and MMCM lock.
module nexys4ddr_reset_request #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int WDT_BITS      = 24,
    parameter int ACK_BITS      = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    input  logic       mmcm_locked,
    input  logic       reset_ack,
    input  logic       cause_clr,
    output logic       areset,
    output logic       busy,
    output logic [4:0] cause
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    // Last ack counter value before it would reach 2^ACK_BITS-1.
    localparam logic [ACK_BITS-1:0] ACK_LAST  = {{(ACK_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_LOCK = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]               btn_sync_q;
    logic [1:0]               lock_sync_q;
    logic [1:0]               ack_sync_q;
    logic                     prev_locked_q;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q;
    logic                     pressed_q;
    logic [WDT_BITS-1:0]      wdt_cnt_q;
    logic [HOLD_W-1:0]        hold_cnt_q;
    logic [ACK_BITS-1:0]      ack_cnt_q;
    logic [4:0]               cause_q, cause_d;
    logic                     areset_q;
    logic                     busy_q;

    logic       btn_pressed_s;
    logic       locked_s;
    logic       ack_s;
    logic       lock_loss;
    logic       wdt_hit;
    logic [3:0] trig_raw;
    logic [3:0] trig;
    logic       ack_timeout;

    assign btn_pressed_s = ~btn_sync_q[1];
    assign locked_s      = lock_sync_q[1];
    assign ack_s         = ack_sync_q[1];
    assign lock_loss     = prev_locked_q & ~locked_s;
    // A kick in the terminal-count cycle suppresses the timeout.
    assign wdt_hit       = wdt_en & ~wdt_kick & (wdt_cnt_q == {WDT_BITS{1'b1}});
    assign trig_raw      = {lock_loss, wdt_hit, sw_req, pressed_q};

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        trig        = 4'b0000;
        ack_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (|trig_raw) begin
                    state_d = ASSERT;
                    trig    = trig_raw;
                end
            end
            ASSERT: begin
                if (hold_cnt_q == HOLD_LAST) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    state_d = WAIT_LOCK;
                end else if (ack_cnt_q == ACK_LAST) begin
                    ack_timeout = 1'b1;
                    state_d     = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s && !pressed_q) state_d = IDLE;
            end
            default: state_d = ASSERT;
        endcase
        // Clear first, then OR in new causes so a same-cycle set survives the clear.
        cause_d = (cause_clr ? 5'b00000 : cause_q) | {ack_timeout, trig};
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_sync_q    <= 2'b11;
            lock_sync_q   <= 2'b00;
            ack_sync_q    <= 2'b00;
            prev_locked_q <= 1'b0;
        end else begin
            btn_sync_q    <= {btn_sync_q[0], btn_n};
            lock_sync_q   <= {lock_sync_q[0], mmcm_locked};
            ack_sync_q    <= {ack_sync_q[0], reset_ack};
            prev_locked_q <= locked_s;
        end
    end

    // Debounce runs in every state; the counter only advances while the input disagrees.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
        end else if (btn_pressed_s != pressed_q) begin
            if (db_cnt_q == {DEBOUNCE_BITS{1'b1}}) begin
                pressed_q <= btn_pressed_s;
                db_cnt_q  <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdt_cnt_q <= '0;
        end else if (state_q != IDLE || state_d != IDLE || !wdt_en || wdt_kick) begin
            wdt_cnt_q <= '0;
        end else if (wdt_cnt_q != {WDT_BITS{1'b1}}) begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ASSERT;
            hold_cnt_q <= '0;
            ack_cnt_q  <= '0;
            cause_q    <= 5'b00000;
            areset_q   <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= (state_q == ASSERT && state_d == ASSERT) ? hold_cnt_q + 1'b1 : '0;
            ack_cnt_q  <= (state_q == WAIT_ACK && state_d == WAIT_ACK) ? ack_cnt_q + 1'b1 : '0;
            cause_q    <= cause_d;
            areset_q   <= (state_d != IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign areset = areset_q;
    assign busy   = busy_q;
    assign cause  = cause_q;

endmodule

// File: tb/tb_nexys4ddr_reset_request.sv
// Directed bench for nexys4ddr_reset_request: power-on, button, software, watchdog,
// lock loss with ack timeout, and reset in the middle of a sequence.
module tb_nexys4ddr_reset_request;

    localparam int DB_BITS  = 4;
    localparam int HOLD     = 8;
    localparam int WDT_BITS = 6;
    localparam int ACK_BITS = 5;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       btn_n       = 1'b1;
    logic       sw_req      = 1'b0;
    logic       wdt_en      = 1'b0;
    logic       wdt_kick    = 1'b0;
    logic       mmcm_locked = 1'b1;
    logic       cause_clr   = 1'b0;
    logic       reset_ack;
    logic       areset;
    logic       busy;
    logic [4:0] cause;

    logic ack_d1       = 1'b0;
    logic ack_d2       = 1'b0;
    logic ack_hold_low = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int n;

    nexys4ddr_reset_request #(
        .DEBOUNCE_BITS(DB_BITS),
        .HOLD_CYCLES  (HOLD),
        .WDT_BITS     (WDT_BITS),
        .ACK_BITS     (ACK_BITS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_n      (btn_n),
        .sw_req     (sw_req),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .mmcm_locked(mmcm_locked),
        .reset_ack  (reset_ack),
        .cause_clr  (cause_clr),
        .areset     (areset),
        .busy       (busy),
        .cause      (cause)
    );

    always #5 clock = ~clock;

    // Downstream domain model: acknowledges areset two cycles late.
    always @(posedge clock) begin
        ack_d1 <= areset;
        ack_d2 <= ack_d1;
    end
    assign reset_ack = ack_d2 & ~ack_hold_low;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until areset reaches level; cycles = -1 when the budget expires.
    task automatic wait_areset(input logic level, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (areset === level) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        // T1 power-on
        repeat (3) tick();
        check("por_areset", areset, 1'b1);
        check("por_busy", busy, 1'b1);
        check("por_cause", cause, 5'b00000);
        reset = 1'b0;
        wait_areset(1'b0, 100, n);
        check("por_release_cycles", n, HOLD + 2);
        check("por_idle_busy", busy, 1'b0);
        check("por_idle_cause", cause, 5'b00000);

        // T2 button with glitches
        for (int g = 0; g < 3; g++) begin
            btn_n = 1'b0;
            repeat (5) tick();
            btn_n = 1'b1;
            repeat (5) tick();
            check("btn_glitch_ignored", areset, 1'b0);
        end
        btn_n = 1'b0;
        // 2 sync + 16 stable cycles to flip, then one edge to register areset
        wait_areset(1'b1, 40, n);
        check("btn_press_latency", n, 19);
        check("btn_cause", cause, 5'b00001);
        repeat (40 - 19) tick();
        check("btn_held_areset", areset, 1'b1);
        check("btn_held_busy", busy, 1'b1);
        btn_n = 1'b1;
        repeat (16) tick();
        check("btn_release_still_high", areset, 1'b1);
        wait_areset(1'b0, 20, n);
        check("btn_release_tail", n, 3);

        // T3 software request and clear
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        check("clr_cause", cause, 5'b00000);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        check("sw_areset", areset, 1'b1);
        check("sw_cause", cause, 5'b00010);
        repeat (2) tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        check("sw_busy_ignored", cause, 5'b00010);
        wait_areset(1'b0, 40, n);
        check("sw_width_tail", n, 7);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        check("sw_clr_cause", cause, 5'b00000);

        // T4 watchdog
        wdt_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat (39) tick();
            wdt_kick = 1'b1;
            tick();
            wdt_kick = 1'b0;
        end
        check("wdt_kicked_no_reset", areset, 1'b0);
        // counter hits 63 at the 63rd edge after the kick edge, areset one edge later
        wait_areset(1'b1, 100, n);
        check("wdt_timeout_cycles", n, 64);
        check("wdt_cause", cause, 5'b00100);
        wait_areset(1'b0, 100, n);
        check("wdt_seq_cycles", n, HOLD + 2);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        repeat (63) tick();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        check("wdt_kick_at_terminal", areset, 1'b0);
        repeat (5) tick();
        check("wdt_after_terminal_kick", areset, 1'b0);
        check("wdt_cause_unchanged", cause, 5'b00100);
        wdt_en = 1'b0;
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;

        // T5 lock loss with ack timeout
        check("lock_pre_cause", cause, 5'b00000);
        ack_hold_low = 1'b1;
        mmcm_locked  = 1'b0;
        wait_areset(1'b1, 10, n);
        check("lock_loss_latency", n, 3);
        check("lock_loss_cause", cause, 5'b01000);
        // ASSERT 8 edges, then 31 WAIT_ACK edges before giving up
        repeat (38) tick();
        check("ack_before_timeout", cause, 5'b01000);
        tick();
        check("ack_timeout_cause", cause, 5'b11000);
        repeat (20) tick();
        check("wait_lock_areset", areset, 1'b1);
        check("wait_lock_busy", busy, 1'b1);
        mmcm_locked  = 1'b1;
        ack_hold_low = 1'b0;
        wait_areset(1'b0, 10, n);
        check("lock_return_cycles", n, 3);
        check("lock_return_busy", busy, 1'b0);

        // T6 reset in the middle of WAIT_LOCK
        mmcm_locked = 1'b0;
        wait_areset(1'b1, 10, n);
        repeat (40) tick();
        check("mid_wait_lock_areset", areset, 1'b1);
        check("mid_cause_sticky", cause, 5'b11000);
        reset = 1'b1;
        tick();
        check("mid_reset_areset", areset, 1'b1);
        check("mid_reset_busy", busy, 1'b1);
        check("mid_reset_cause", cause, 5'b00000);
        reset       = 1'b0;
        mmcm_locked = 1'b1;
        wait_areset(1'b0, 40, n);
        check("mid_reset_full_seq", n, HOLD + 2);
        check("mid_reset_final_cause", cause, 5'b00000);
        check("mid_reset_final_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
